// File: rtl/ooo_divide_unit.sv
// Iterative 32-step restoring divider for DIV/DIVU/REM/REMU with tagged completion.
// Zero-divisor and signed-overflow results bypass the loop and complete one cycle after issue.
//   state | meaning
//   IDLE  | waiting for an op, ready when not reset/flushed
//   BUSY  | one restoring iteration per cycle on operand magnitudes
//   DONE  | one-cycle completion strobe with tag and result
module ooo_divide_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              ready,
  input  logic [1:0]        div_type,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [TAG_W-1:0]  rd_in,
  input  logic              flush,
  output logic              valid_div,
  output logic [TAG_W-1:0]  rd_div,
  output logic [DATA_W-1:0] data_div
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TAG_W-1:0]  rd_q;
  logic              is_rem_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  word_t             quo_q;
  logic [DATA_W:0]   rem_q;
  word_t             dvsr_q;
  word_t             res_q;

  logic  is_signed_in;
  logic  a_neg_in;
  logic  b_neg_in;
  logic  div0_in;
  logic  ovf_in;
  word_t mag_a;
  word_t mag_b;
  word_t spec_res;

  always_comb begin
    is_signed_in = ~div_type[0];
    a_neg_in     = is_signed_in & rs1_data[DATA_W-1];
    b_neg_in     = is_signed_in & rs2_data[DATA_W-1];
    mag_a        = a_neg_in ? -rs1_data : rs1_data;
    mag_b        = b_neg_in ? -rs2_data : rs2_data;
    div0_in      = (rs2_data == '0);
    ovf_in       = is_signed_in & (rs1_data == {1'b1, {(DATA_W-1){1'b0}}}) & (rs2_data == '1);
    if (div_type[1])
      spec_res = div0_in ? rs1_data : '0;
    else
      spec_res = div0_in ? '1 : {1'b1, {(DATA_W-1){1'b0}}};
  end

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            step_ge;
  logic [DATA_W:0] step_rem;
  word_t           step_quo;
  word_t           fix_quo;
  word_t           fix_rem;
  word_t           fin_res;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted  = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    diff     = shifted - {1'b0, dvsr_q};
    step_ge  = ~diff[DATA_W];
    step_rem = step_ge ? diff : shifted;
    step_quo = {quo_q[DATA_W-2:0], step_ge};
    fix_quo  = neg_quo_q ? -step_quo : step_quo;
    fix_rem  = neg_rem_q ? -step_rem[DATA_W-1:0] : step_rem[DATA_W-1:0];
    fin_res  = is_rem_q ? fix_rem : fix_quo;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      res_q     <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rd_q     <= rd_in;
            is_rem_q <= div_type[1];
            if (div0_in || ovf_in) begin
              res_q   <= spec_res;
              state_q <= DONE;
            end else begin
              quo_q     <= mag_a;
              rem_q     <= '0;
              dvsr_q    <= mag_b;
              neg_quo_q <= a_neg_in ^ b_neg_in;
              neg_rem_q <= a_neg_in;
              cnt_q     <= CNT_W'(DATA_W - 1);
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          quo_q <= step_quo;
          rem_q <= step_rem;
          if (cnt_q == '0) begin
            res_q   <= fin_res;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset and flush gate the handshake outputs in the same cycle they are seen.
  always_comb begin
    ready     = (state_q == IDLE) & ~RST & ~flush;
    valid_div = (state_q == DONE) & ~RST & ~flush;
    rd_div    = valid_div ? rd_q : '0;
    data_div  = valid_div ? res_q : '0;
  end

endmodule

// File: tb/tb_ooo_divide_unit.sv
// Directed and randomized checks of ooo_divide_unit against an arithmetic reference model.
module tb_ooo_divide_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        flush;
  logic [1:0]  div_type;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        ready;
  logic        valid_div;
  logic [4:0]  rd_div;
  logic [31:0] data_div;

  int checks = 0;
  int errors = 0;

  ooo_divide_unit #(.DATA_W(32), .TAG_W(5)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .ready     (ready),
    .div_type  (div_type),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .flush     (flush),
    .valid_div (valid_div),
    .rd_div    (rd_div),
    .data_div  (data_div)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int  sa;
    int  sb;
    bit  ovf;
    logic [31:0] r;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = 32'h8000_0000; else r = sa / sb;
      2'b01:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   if (b == 0) r = a; else if (ovf) r = 32'd0; else r = sa % sb;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issues one op at the current negedge, follows it to completion, and ends one cycle after DONE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit poke);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    bit          rdy_bad;
    bit          out_bad;
    exp     = ref_result(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 33;
    check("ready_before_issue", ready, 1);
    start    = 1'b1;
    div_type = op;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    @(negedge CLK);
    start    = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    div_type = 2'($urandom);
    rd_in    = 5'($urandom);
    lat      = 1;
    rdy_bad  = 0;
    out_bad  = 0;
    while (!valid_div && lat < 40) begin
      if (ready !== 1'b0) rdy_bad = 1;
      if (rd_div !== 5'd0 || data_div !== 32'd0) out_bad = 1;
      start = (poke && lat == 5);
      @(negedge CLK);
      lat++;
    end
    start = 1'b0;
    check("valid_seen", valid_div, 1);
    check("latency", lat, exp_lat);
    check("rd_div", rd_div, rd);
    check("data_div", data_div, exp);
    check("ready_in_done", ready, 0);
    check("ready_low_while_busy", rdy_bad, 0);
    check("outputs_zero_while_busy", out_bad, 0);
    @(negedge CLK);
    check("valid_one_cycle", valid_div, 0);
    check("data_zero_after_done", data_div, 0);
    check("ready_after_done", ready, 1);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          sel;
    bit          seen;

    RST = 1'b1; start = 1'b0; flush = 1'b0; div_type = 2'b00;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(negedge CLK);
    start = 1'b1;
    #1;
    check("rst_ready", ready, 0);
    check("rst_valid", valid_div, 0);
    check("rst_rd", rd_div, 0);
    check("rst_data", data_div, 0);
    @(negedge CLK);
    start = 1'b0;
    RST = 1'b0;
    #1;
    check("ready_after_rst", ready, 1);

    do_op(2'b00, 32'h0000_0014, 32'hFFFF_FFFD, 5'd7, 0);
    do_op(2'b10, 32'hFFFF_FFEC, 32'd3, 5'd3, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'd16, 5'd12, 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd16, 5'd31, 0);
    do_op(2'b01, 32'd5, 32'd0, 5'd1, 0);
    do_op(2'b11, 32'd7, 32'd0, 5'd2, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    do_op(2'b00, 32'd7, 32'd0, 5'd10, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd11, 0);
    do_op(2'b01, 32'd100, 32'd7, 5'd0, 0);
    do_op(2'b00, 32'd1000, 32'd7, 5'd9, 1);

    // Flush ten cycles into BUSY, then issue immediately.
    start = 1'b1; div_type = 2'b01; rs1_data = 32'd100; rs2_data = 32'd3; rd_in = 5'd4;
    @(negedge CLK);
    start = 1'b0;
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    #1;
    check("flush_busy_ready", ready, 0);
    check("flush_busy_valid", valid_div, 0);
    @(negedge CLK);
    flush = 1'b0;
    #1;
    check("ready_after_flush", ready, 1);
    check("valid_after_flush", valid_div, 0);
    do_op(2'b01, 32'd9, 32'd3, 5'd5, 0);

    // Flush during DONE suppresses the strobe.
    start = 1'b1; div_type = 2'b01; rs1_data = 32'd5; rs2_data = 32'd0; rd_in = 5'd6;
    @(negedge CLK);
    start = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_done_valid", valid_div, 0);
    check("flush_done_rd", rd_div, 0);
    check("flush_done_data", data_div, 0);
    @(negedge CLK);
    flush = 1'b0;
    #1;
    check("ready_after_done_flush", ready, 1);
    check("valid_after_done_flush", valid_div, 0);

    // Flush with start wins.
    flush = 1'b1; start = 1'b1; div_type = 2'b01; rs1_data = 32'd100; rs2_data = 32'd3;
    #1;
    check("flush_start_ready", ready, 0);
    @(negedge CLK);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_start_not_accepted", ready, 1);
    check("flush_start_no_valid", valid_div, 0);

    // Reset mid-BUSY overrides start.
    start = 1'b1; div_type = 2'b00; rs1_data = 32'd12345; rs2_data = 32'd17; rd_in = 5'd13;
    @(negedge CLK);
    start = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1; start = 1'b1;
    #1;
    check("rst_busy_ready", ready, 0);
    check("rst_busy_valid", valid_div, 0);
    @(negedge CLK);
    start = 1'b0;
    check("rst_busy_rd", rd_div, 0);
    check("rst_busy_data", data_div, 0);
    RST = 1'b0;
    #1;
    check("ready_after_busy_rst", ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (valid_div !== 1'b0) seen = 1;
    end
    check("no_valid_after_busy_rst", seen, 0);

    for (int i = 0; i < 60; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      sel  = $urandom_range(0, 9);
      case (sel)
        0:       r_b = 32'd0;
        1:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2:       r_b = $urandom_range(1, 20);
        3:       r_b = 32'hFFFF_FFFF;
        4:       begin r_a = $urandom_range(0, 50); r_b = $urandom; end
        default: r_b = $urandom;
      endcase
      do_op(r_op, r_a, r_b, 5'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
